// File: rtl/rv32_fetch_pkg.sv
// Shared fetch-side encodings: FSM states, trap-cause codes and default vectors.
package rv32_fetch_pkg;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HALT = 2'd1,
      ST_TRAP = 2'd2
   } fetch_state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'd0,
      CAUSE_MISALIGN = 2'd1,
      CAUSE_RANGE    = 2'd2
   } trap_cause_e;

   localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] DEF_TRAP_PC    = 32'h0000_0100;
   localparam int          DEF_IMEM_WORDS = 256;

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational word-address legality check: alignment first, then range.
module fetch_addr_check
   import rv32_fetch_pkg::*;
#(
   parameter int IMEM_WORDS = DEF_IMEM_WORDS
) (
   input  logic [31:0] i_addr,
   output logic        o_fault,
   output logic [1:0]  o_cause
);

   localparam logic [29:0] LIMIT = 30'(IMEM_WORDS);

   logic w_misalign;
   logic w_range;

   assign w_misalign = (i_addr[1:0] != 2'b00);
   assign w_range    = (i_addr[31:2] >= LIMIT);

   always_comb begin
      o_cause = CAUSE_NONE;
      if (w_misalign)   o_cause = CAUSE_MISALIGN;
      else if (w_range) o_cause = CAUSE_RANGE;
   end

   assign o_fault = w_misalign | w_range;

endmodule

// File: rtl/pc_fetch.sv
// Architectural PC register with next-PC select, halt/resume and fetch-trap sequencing.
module pc_fetch
   import rv32_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
   parameter logic [31:0] TRAP_PC    = DEF_TRAP_PC,
   parameter int          IMEM_WORDS = DEF_IMEM_WORDS
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_target,
   input  logic        i_halt_req,
   input  logic        i_resume,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_plus4,
   output logic        o_fetch_valid,
   output logic [1:0]  o_state,
   output logic [1:0]  o_trap_cause,
   output logic [31:0] o_trap_addr,
   output logic [31:0] o_instret
);

   fetch_state_e r_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_instret;
   logic [31:0]  r_trap_addr;
   logic [1:0]   r_trap_cause;
   logic         r_fetch_valid;

   logic [31:0]  w_pc_plus4;
   logic [31:0]  w_cand;
   logic         w_fault;
   logic [1:0]   w_cause;

   assign w_pc_plus4 = r_pc + 32'd4;
   // halt_req wins over redirect when choosing the candidate
   assign w_cand     = (i_redirect && !i_halt_req) ? i_redirect_target : w_pc_plus4;

   fetch_addr_check #(.IMEM_WORDS(IMEM_WORDS)) u_chk (
      .i_addr  (w_cand),
      .o_fault (w_fault),
      .o_cause (w_cause)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_RUN;
         r_pc          <= RESET_PC;
         r_instret     <= 32'd0;
         r_trap_addr   <= 32'd0;
         r_trap_cause  <= CAUSE_NONE;
         r_fetch_valid <= 1'b1;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (!i_stall) begin
                  if (w_fault) begin
                     r_state       <= ST_TRAP;
                     r_pc          <= TRAP_PC;
                     r_trap_cause  <= w_cause;
                     r_trap_addr   <= w_cand;
                     r_fetch_valid <= 1'b0;
                  end else begin
                     r_pc      <= w_cand;
                     r_instret <= r_instret + 32'd1;
                     if (i_halt_req) begin
                        r_state       <= ST_HALT;
                        r_fetch_valid <= 1'b0;
                     end
                  end
               end
            end
            ST_HALT: begin
               if (i_resume) begin
                  r_state       <= ST_RUN;
                  r_fetch_valid <= 1'b1;
               end
            end
            ST_TRAP: begin
               if (i_resume) begin
                  r_state       <= ST_RUN;
                  r_trap_cause  <= CAUSE_NONE;
                  r_fetch_valid <= 1'b1;
               end
            end
            default: begin
               r_state       <= ST_RUN;
               r_fetch_valid <= 1'b1;
            end
         endcase
      end
   end

   assign o_pc          = r_pc;
   assign o_pc_plus4    = w_pc_plus4;
   assign o_fetch_valid = r_fetch_valid;
   assign o_state       = r_state;
   assign o_trap_cause  = r_trap_cause;
   assign o_trap_addr   = r_trap_addr;
   assign o_instret     = r_instret;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: sequential fetch, stall, traps, halt/resume, async reset.
module tb_pc_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_stall, i_redirect, i_halt_req, i_resume;
   logic [31:0] i_redirect_target;
   logic [31:0] o_pc, o_pc_plus4, o_trap_addr, o_instret;
   logic        o_fetch_valid;
   logic [1:0]  o_state, o_trap_cause;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pc_fetch dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .i_stall           (i_stall),
      .i_redirect        (i_redirect),
      .i_redirect_target (i_redirect_target),
      .i_halt_req        (i_halt_req),
      .i_resume          (i_resume),
      .o_pc              (o_pc),
      .o_pc_plus4        (o_pc_plus4),
      .o_fetch_valid     (o_fetch_valid),
      .o_state           (o_state),
      .o_trap_cause      (o_trap_cause),
      .o_trap_addr       (o_trap_addr),
      .o_instret         (o_instret)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // one rising edge, then sample on the falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_core(input string tag, input logic [31:0] pc, input logic [1:0] st,
                           input logic [31:0] ir);
      chk({tag, ".pc"}, o_pc, pc);
      chk({tag, ".state"}, {30'd0, o_state}, {30'd0, st});
      chk({tag, ".instret"}, o_instret, ir);
      chk({tag, ".fv"}, {31'd0, o_fetch_valid}, {31'd0, (st == 2'd0)});
   endtask

   initial begin
      rst_n = 1'b0; i_stall = 0; i_redirect = 0; i_halt_req = 0; i_resume = 0;
      i_redirect_target = 32'd0;
      #12;
      chk_core("rst", 32'h0, 2'd0, 32'd0);
      chk("rst.cause", {30'd0, o_trap_cause}, 32'd0);
      chk("rst.taddr", o_trap_addr, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // free run
      step(); chk("seq1.pc", o_pc, 32'h4);
      step(); chk("seq2.pc", o_pc, 32'h8);
      step(); chk_core("seq3", 32'hC, 2'd0, 32'd3);
      chk("seq3.plus4", o_pc_plus4, 32'h10);

      // stalled redirect
      i_redirect = 1; i_redirect_target = 32'h40; i_stall = 1;
      step(); chk_core("stall1", 32'hC, 2'd0, 32'd3);
      step(); chk_core("stall2", 32'hC, 2'd0, 32'd3);
      i_stall = 0;
      step(); chk_core("redir", 32'h40, 2'd0, 32'd4);

      // stalled faulting target does nothing
      i_redirect_target = 32'h42; i_stall = 1;
      step(); chk_core("stallf", 32'h40, 2'd0, 32'd4);
      chk("stallf.cause", {30'd0, o_trap_cause}, 32'd0);
      i_stall = 0;
      step(); chk_core("mis", 32'h100, 2'd2, 32'd4);
      chk("mis.cause", {30'd0, o_trap_cause}, 32'd1);
      chk("mis.taddr", o_trap_addr, 32'h42);
      i_redirect = 0;
      step(); chk_core("trap.hold", 32'h100, 2'd2, 32'd4);
      i_resume = 1;
      step(); chk_core("mis.res", 32'h100, 2'd0, 32'd4);
      chk("mis.res.cause", {30'd0, o_trap_cause}, 32'd0);
      chk("mis.res.taddr", o_trap_addr, 32'h42);
      i_resume = 0;
      step(); chk_core("post.res", 32'h104, 2'd0, 32'd5);

      // sequential run off the end of imem
      i_redirect = 1; i_redirect_target = 32'h3F8;
      step(); chk_core("to3f8", 32'h3F8, 2'd0, 32'd6);
      i_redirect = 0;
      step(); chk_core("to3fc", 32'h3FC, 2'd0, 32'd7);
      step(); chk_core("rng", 32'h100, 2'd2, 32'd7);
      chk("rng.cause", {30'd0, o_trap_cause}, 32'd2);
      chk("rng.taddr", o_trap_addr, 32'h400);
      i_resume = 1;
      step(); chk_core("rng.res", 32'h100, 2'd0, 32'd7);
      i_resume = 0;

      // halt with simultaneous redirect
      i_redirect = 1; i_redirect_target = 32'h10;
      step(); chk_core("to10", 32'h10, 2'd0, 32'd8);
      i_redirect_target = 32'h80; i_halt_req = 1;
      step(); chk_core("halt", 32'h14, 2'd1, 32'd9);
      step(); chk_core("halt.ign1", 32'h14, 2'd1, 32'd9);
      i_halt_req = 0; i_stall = 1;
      step(); chk_core("halt.ign2", 32'h14, 2'd1, 32'd9);
      i_redirect = 0; i_stall = 0; i_resume = 1;
      step(); chk_core("halt.res", 32'h14, 2'd0, 32'd9);
      step(); chk_core("run.resume", 32'h18, 2'd0, 32'd10);
      i_resume = 0;

      // top-of-space target is out of range
      i_redirect = 1; i_redirect_target = 32'hFFFF_FFFC;
      step(); chk_core("hi", 32'h100, 2'd2, 32'd10);
      chk("hi.cause", {30'd0, o_trap_cause}, 32'd2);
      chk("hi.taddr", o_trap_addr, 32'hFFFF_FFFC);
      i_redirect = 0;

      // async reset mid-trap
      #2 rst_n = 1'b0;
      #1;
      chk_core("arst", 32'h0, 2'd0, 32'd0);
      chk("arst.cause", {30'd0, o_trap_cause}, 32'd0);
      chk("arst.taddr", o_trap_addr, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      step(); chk_core("arst.run", 32'h4, 2'd0, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
